io_bus_responder: RTL and testbench

- Peripheral-side responder for CPU I/O accesses in the single-cycle RISC-V core.
- Accepts the io_read/io_write strobes and ALU address that the controller produces for the 0xFFFFFCxx I/O window.
- Returns read data for MemOrIOtoReg and registers writes to LEDs and seven-segment value.
- Synchronises switches, debounces buttons, keeps sticky press flags, and runs a free-running cycle counter.

---
 rtl/io_map_pkg.sv | 24 ++
 rtl/button_debouncer.sv | 107 ++++++++++
 rtl/io_bus_responder.sv | 108 ++++++++++
 tb/tb_io_bus_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared definitions for the CPU I/O window responder: register offsets,
// the button debounce state encoding and the address decode helper.
package io_map_pkg;

    localparam logic [9:0] LED_OFF       = 10'h000;
    localparam logic [9:0] SW_OFF        = 10'h010;
    localparam logic [9:0] BTN_LVL_OFF   = 10'h020;
    localparam logic [9:0] BTN_PRESS_OFF = 10'h024;
    localparam logic [9:0] SEG_OFF       = 10'h030;
    localparam logic [9:0] CYC_OFF       = 10'h040;

    typedef enum logic [1:0] {
        DB_RELEASED      = 2'd0,
        DB_CHECK_PRESS   = 2'd1,
        DB_PRESSED       = 2'd2,
        DB_CHECK_RELEASE = 2'd3
    } db_state_e;

    // Word-granular match; the byte offset bits are ignored.
    function automatic logic addr_hit(input logic [9:0] a, input logic [9:0] off);
        return (a[9:2] == off[9:2]);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: two-flop synchroniser followed by a debounce FSM. level is
// high while the button counts as held; press_pulse marks an accepted press.
module button_debouncer
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    db_state_e     r_state;
    db_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_pulse;
    logic          w_pulse_nxt;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
        end
    end

    // Debounce state, stability counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DB_RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Next state: a change is accepted only after it has stayed stable
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            DB_RELEASED: begin
                if (r_sync) begin
                    w_state_nxt = DB_CHECK_PRESS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = DB_RELEASED;
                end
            end
            DB_CHECK_PRESS: begin
                if (!r_sync) begin
                    w_state_nxt = DB_RELEASED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_PRESSED;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DB_PRESSED: begin
                if (!r_sync) begin
                    w_state_nxt = DB_CHECK_RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = DB_PRESSED;
                end
            end
            DB_CHECK_RELEASE: begin
                if (r_sync) begin
                    w_state_nxt = DB_PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_RELEASED;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = DB_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == DB_PRESSED) || (w_state_nxt == DB_CHECK_RELEASE);
    end

    assign level       = r_level;
    assign press_pulse = r_pulse;

endmodule

// File: rtl/io_bus_responder.sv
// Peripheral responder for the core's 0xFFFFFCxx I/O window: LED and
// seven-segment registers, synchronised switches, debounced buttons, cycle counter.
module io_bus_responder
    import io_map_pkg::*;
#(
    parameter int SW_W            = 16,
    parameter int BTN_W           = 5,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             io_read,
    input  logic             io_write,
    input  logic [9:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  switch_in,
    input  logic [BTN_W-1:0] button_in,
    output logic [15:0]      led_out,
    output logic [31:0]      seg_value
);

    logic [15:0]      r_led;
    logic [31:0]      r_seg;
    logic [31:0]      r_cycles;
    logic [SW_W-1:0]  r_sw_meta;
    logic [SW_W-1:0]  r_sw_sync;
    logic [BTN_W-1:0] r_press;
    logic [BTN_W-1:0] w_btn_level;
    logic [BTN_W-1:0] w_btn_pulse;
    logic             w_press_clr;
    logic [31:0]      w_rdata;

    for (genvar g = 0; g < BTN_W; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (button_in[g]),
            .level      (w_btn_level[g]),
            .press_pulse(w_btn_pulse[g])
        );
    end

    // Switch synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // CPU-writable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 16'h0000;
            r_seg <= 32'h0000_0000;
        end else if (io_write) begin
            if (addr_hit(addr, LED_OFF)) begin
                r_led <= wdata[15:0];
            end
            if (addr_hit(addr, SEG_OFF)) begin
                r_seg <= wdata;
            end
        end
    end

    // A press pulse in the same cycle as a clearing read still sets its flag
    assign w_press_clr = io_read && addr_hit(addr, BTN_PRESS_OFF);

    // Sticky press flags and free-running cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press  <= '0;
            r_cycles <= 32'h0000_0000;
        end else begin
            r_press  <= (w_press_clr ? '0 : r_press) | w_btn_pulse;
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // Zero-latency read mux; pre-edge state is returned even during a write
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (io_read) begin
            case (addr[9:2])
                LED_OFF[9:2]:       w_rdata = 32'(r_led);
                SW_OFF[9:2]:        w_rdata = 32'(r_sw_sync);
                BTN_LVL_OFF[9:2]:   w_rdata = 32'(w_btn_level);
                BTN_PRESS_OFF[9:2]: w_rdata = 32'(r_press);
                SEG_OFF[9:2]:       w_rdata = r_seg;
                CYC_OFF[9:2]:       w_rdata = r_cycles;
                default:            w_rdata = 32'h0000_0000;
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    assign rdata     = w_rdata;
    assign led_out   = r_led;
    assign seg_value = r_seg;

endmodule

// File: tb/tb_io_bus_responder.sv
// Randomised self-checking bench for io_bus_responder against a cycle-level
// behavioural model of the register map, synchronisers and debounce rules.
module tb_io_bus_responder;

    localparam int DB_N = 4;
    localparam logic [9:0] A_LED  = 10'h000;
    localparam logic [9:0] A_SW   = 10'h010;
    localparam logic [9:0] A_BTNL = 10'h020;
    localparam logic [9:0] A_BTNP = 10'h024;
    localparam logic [9:0] A_SEG  = 10'h030;
    localparam logic [9:0] A_CYC  = 10'h040;
    localparam logic [9:0] A_UNM  = 10'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_read;
    logic        io_write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] switch_in;
    logic [4:0]  button_in;
    logic [15:0] led_out;
    logic [31:0] seg_value;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [15:0] m_led;
    logic [31:0] m_seg;
    logic [4:0]  m_press;
    logic [31:0] m_cyc;
    logic [15:0] m_sw_h1;
    logic [15:0] m_sw_sync;
    logic [4:0]  m_btn_h1;
    logic [4:0]  m_btn_sync;
    logic [4:0]  m_level;
    logic [4:0]  m_pend;
    int          m_run [5];

    io_bus_responder #(
        .SW_W(16),
        .BTN_W(5),
        .DEBOUNCE_CYCLES(DB_N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_read  (io_read),
        .io_write (io_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .switch_in(switch_in),
        .button_in(button_in),
        .led_out  (led_out),
        .seg_value(seg_value)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_led = 16'h0; m_seg = 32'h0; m_press = 5'h0; m_cyc = 32'h0;
        m_sw_h1 = 16'h0; m_sw_sync = 16'h0; m_btn_h1 = 5'h0; m_btn_sync = 5'h0;
        m_level = 5'h0; m_pend = 5'h0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
    endtask

    // A button level flips once the synchronised input has disagreed with it
    // on DB_N+1 consecutive clock edges; the press flag follows one edge later.
    task automatic model_update();
        logic [4:0] new_pend;
        new_pend = 5'h0;
        if (io_write) begin
            if (addr[9:2] == 8'h00) m_led = wdata[15:0];
            else if (addr[9:2] == 8'h0C) m_seg = wdata;
        end
        if (io_read && addr[9:2] == 8'h09) m_press = 5'h0;
        m_press = m_press | m_pend;
        for (int i = 0; i < 5; i++) begin
            if (m_btn_sync[i] != m_level[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB_N + 1) begin
                    m_level[i]  = m_btn_sync[i];
                    m_run[i]    = 0;
                    new_pend[i] = m_btn_sync[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pend     = new_pend;
        m_btn_sync = m_btn_h1;
        m_btn_h1   = button_in;
        m_sw_sync  = m_sw_h1;
        m_sw_h1    = switch_in;
        m_cyc      = m_cyc + 32'd1;
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] v;
        v = 32'h0;
        if (io_read) begin
            case (addr[9:2])
                8'h00:   v = {16'h0, m_led};
                8'h04:   v = {16'h0, m_sw_sync};
                8'h08:   v = {27'h0, m_level};
                8'h09:   v = {27'h0, m_press};
                8'h0C:   v = m_seg;
                8'h10:   v = m_cyc;
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic idle();
        io_read = 1'b0; io_write = 1'b0; addr = 10'h0; wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); switch_in = 16'hFFFF; button_in = 5'h0;
        model_reset();
        repeat (3) tick();
        io_read = 1'b1; addr = A_CYC; #1;
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_cyc: got %h expected %h", rdata, 32'h0); end
        addr = A_SW; #1;
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_sw: got %h expected %h", rdata, 32'h0); end
        n_checks++; if (led_out !== 16'h0) begin n_errors++; $display("FAIL reset_led: got %h expected %h", led_out, 16'h0); end
        n_checks++; if (seg_value !== 32'h0) begin n_errors++; $display("FAIL reset_seg: got %h expected %h", seg_value, 32'h0); end
        switch_in = 16'h0; idle();
        @(negedge clk); rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_led_write();
        io_write = 1'b1; addr = A_LED; wdata = 32'h1234ABCD;
        tick(); idle();
        n_checks++; if (led_out !== 16'hABCD) begin n_errors++; $display("FAIL led_write: got %h expected %h", led_out, 16'hABCD); end
        io_read = 1'b1; addr = A_LED; #1;
        n_checks++; if (rdata !== 32'h0000ABCD) begin n_errors++; $display("FAIL led_read: got %h expected %h", rdata, 32'h0000ABCD); end
        tick(); idle();
        for (int k = 0; k < 8; k++) begin
            io_write = 1'b1;
            addr  = ($urandom_range(0, 1) == 0 ? A_LED : A_SEG) | 10'($urandom_range(0, 3));
            wdata = $urandom;
            tick(); idle();
            n_checks++; if (led_out !== m_led) begin n_errors++; $display("FAIL rand_led: got %h expected %h", led_out, m_led); end
            n_checks++; if (seg_value !== m_seg) begin n_errors++; $display("FAIL rand_seg: got %h expected %h", seg_value, m_seg); end
        end
    endtask

    task automatic test_switch_sync();
        switch_in = 16'h00A5; io_read = 1'b1; addr = A_SW; #1;
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL sw_cycle1: got %h expected %h", rdata, 32'h0); end
        tick();
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL sw_cycle2: got %h expected %h", rdata, 32'h0); end
        tick();
        n_checks++; if (rdata !== 32'h000000A5) begin n_errors++; $display("FAIL sw_cycle3: got %h expected %h", rdata, 32'h000000A5); end
        io_read = 1'b0; #1;
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL sw_noread: got %h expected %h", rdata, 32'h0); end
        tick();
    endtask

    task automatic test_button_glitch_and_hold();
        io_read = 1'b1; addr = A_BTNL; button_in = 5'b00100;
        tick(); tick();
        button_in = 5'b00000;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++; if (rdata !== exp_rdata()) begin n_errors++; $display("FAIL glitch_level: got %h expected %h", rdata, exp_rdata()); end
            tick();
        end
        addr = A_BTNP; #1;
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL glitch_flag: got %h expected %h", rdata, 32'h0); end
        tick();
        addr = A_BTNL; button_in = 5'b00100;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++; if (rdata !== exp_rdata()) begin n_errors++; $display("FAIL hold_level: got %h expected %h", rdata, exp_rdata()); end
            tick();
        end
        n_checks++; if (rdata !== 32'h04) begin n_errors++; $display("FAIL hold_level_final: got %h expected %h", rdata, 32'h04); end
        addr = A_BTNP; #1;
        n_checks++; if (rdata !== 32'h04) begin n_errors++; $display("FAIL hold_flag: got %h expected %h", rdata, 32'h04); end
        tick();
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL flag_cleared: got %h expected %h", rdata, 32'h0); end
        addr = A_BTNL; button_in = 5'b00000;
        for (int k = 0; k < 12; k++) begin
            #1;
            n_checks++; if (rdata !== exp_rdata()) begin n_errors++; $display("FAIL release_level: got %h expected %h", rdata, exp_rdata()); end
            tick();
        end
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL release_final: got %h expected %h", rdata, 32'h0); end
        idle();
    endtask

    task automatic test_set_wins();
        bit found;
        found = 1'b0;
        io_read = 1'b1; addr = A_BTNP; tick(); idle();
        button_in = 5'b00001;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_pend[0]) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++; $display("FAIL set_wins_timeout: got no press within %0d cycles expected one", 20);
        end else begin
            io_read = 1'b1; addr = A_BTNP; #1;
            n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL set_wins_read0: got %h expected %h", rdata, 32'h0); end
            tick();
            n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL set_wins_read1: got %h expected %h", rdata, 32'h1); end
            tick();
            n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL set_wins_read2: got %h expected %h", rdata, 32'h0); end
        end
        idle(); button_in = 5'b00000;
        repeat (12) tick();
    endtask

    task automatic test_ro_unmapped();
        logic [15:0] led_before;
        logic [31:0] seg_before;
        led_before = m_led; seg_before = m_seg;
        io_write = 1'b1; wdata = 32'h0000_0001; addr = A_SW; tick();
        addr = A_UNM; tick(); idle();
        n_checks++; if (led_out !== led_before) begin n_errors++; $display("FAIL ro_led: got %h expected %h", led_out, led_before); end
        n_checks++; if (seg_value !== seg_before) begin n_errors++; $display("FAIL ro_seg: got %h expected %h", seg_value, seg_before); end
        io_read = 1'b1; addr = A_SW; #1;
        n_checks++; if (rdata !== {16'h0, m_sw_sync}) begin n_errors++; $display("FAIL ro_sw_read: got %h expected %h", rdata, {16'h0, m_sw_sync}); end
        addr = A_UNM; #1;
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL unmapped_read: got %h expected %h", rdata, 32'h0); end
        idle(); io_write = 1'b1; addr = A_SEG; wdata = 32'hDEADBEEF; tick(); idle();
        n_checks++; if (seg_value !== 32'hDEADBEEF) begin n_errors++; $display("FAIL seg_write: got %h expected %h", seg_value, 32'hDEADBEEF); end
        io_read = 1'b1; io_write = 1'b1; addr = A_SEG; wdata = 32'h0BADF00D; #1;
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rw_old_value: got %h expected %h", rdata, 32'hDEADBEEF); end
        tick(); io_write = 1'b0; #1;
        n_checks++; if (rdata !== 32'h0BADF00D) begin n_errors++; $display("FAIL rw_new_value: got %h expected %h", rdata, 32'h0BADF00D); end
        idle();
    endtask

    task automatic test_cycles();
        io_read = 1'b1; addr = A_CYC; #1;
        n_checks++; if (rdata !== m_cyc) begin n_errors++; $display("FAIL cyc_track: got %h expected %h", rdata, m_cyc); end
        force dut.r_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycles;
        m_cyc = 32'hFFFF_FFFE; #1;
        n_checks++; if (rdata !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL cyc_fffe: got %h expected %h", rdata, 32'hFFFF_FFFE); end
        tick();
        n_checks++; if (rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cyc_ffff: got %h expected %h", rdata, 32'hFFFF_FFFF); end
        tick();
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL cyc_wrap: got %h expected %h", rdata, 32'h0); end
        tick();
        n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL cyc_after_wrap: got %h expected %h", rdata, 32'h1); end
        idle();
    endtask

    task automatic test_random_traffic();
        for (int k = 0; k < 300; k++) begin
            io_read  = 1'($urandom_range(0, 1));
            io_write = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: addr = A_LED;
                1: addr = A_SW;
                2: addr = A_BTNL;
                3: addr = A_BTNP;
                4: addr = A_SEG;
                5: addr = A_CYC;
                6: addr = A_UNM;
                default: addr = 10'h3FC;
            endcase
            addr  = addr | 10'($urandom_range(0, 3));
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0) switch_in = 16'($urandom);
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 5) == 0) button_in[b] = ~button_in[b];
            end
            #1;
            n_checks++; if (rdata !== exp_rdata()) begin n_errors++; $display("FAIL rand_rdata: addr %h got %h expected %h", addr, rdata, exp_rdata()); end
            n_checks++; if (led_out !== m_led) begin n_errors++; $display("FAIL rand_led_out: got %h expected %h", led_out, m_led); end
            n_checks++; if (seg_value !== m_seg) begin n_errors++; $display("FAIL rand_seg_value: got %h expected %h", seg_value, m_seg); end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        io_write = 1'b1; addr = A_LED; wdata = 32'h0000_5A5A; tick(); idle();
        n_checks++; if (led_out !== 16'h5A5A) begin n_errors++; $display("FAIL midrun_led_pre: got %h expected %h", led_out, 16'h5A5A); end
        #2;
        rst_n = 1'b0; io_read = 1'b1; addr = A_CYC; #1;
        n_checks++; if (led_out !== 16'h0) begin n_errors++; $display("FAIL midrun_led_async: got %h expected %h", led_out, 16'h0); end
        n_checks++; if (seg_value !== 32'h0) begin n_errors++; $display("FAIL midrun_seg_async: got %h expected %h", seg_value, 32'h0); end
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL midrun_rdata_async: got %h expected %h", rdata, 32'h0); end
        model_reset(); idle(); button_in = 5'h0; switch_in = 16'h0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_led_write();
        test_switch_sync();
        test_button_glitch_and_hold();
        test_set_wins();
        test_ro_unmapped();
        test_cycles();
        test_random_traffic();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before %0d ns", 500000);
        $fatal(1);
    end

endmodule
